// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART:
//   - parity mode encodings (none / odd / even)
//   - FSM state encoding shared by the transmitter and receiver
//   - calc_parity(): parity bit for a data word under a given mode
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Data is zero-extended to 16 bits by the caller; zero padding does not
  // change the reduction XOR, so one function serves every DATA_W.
  function automatic logic calc_parity(input logic [15:0] data,
                                       input logic [1:0]  mode);
    logic par_s;
    case (mode)
      PAR_ODD:  par_s = ~^data;
      PAR_EVEN: par_s = ^data;
      PAR_NONE: par_s = 1'b0;
      default:  par_s = 1'b0;
    endcase
    return par_s;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// UART receiver: 2-flop synchroniser, falling-edge start detection, mid-bit
// sampling, parity and stop-bit checking.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   rx          asynchronous serial input
//   read_vld    one-cycle pulse, a frame has been received
//   read_data   last received word (held until next pulse)
//   parity_err  parity mismatch for the last frame (qualified by read_vld)
//   frame_err   first stop bit sampled low (qualified by read_vld)
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              read_vld,
  output logic [DATA_W-1:0] read_data,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  logic              sync1_r;
  logic              sync2_r;
  logic              rx_prev_r;
  logic              rx_s;
  logic              fall_s;
  uart_state_e       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_bit_r;
  logic              read_vld_r;
  logic [DATA_W-1:0] read_data_r;
  logic              parity_err_r;
  logic              frame_err_r;
  logic              half_done_s;
  logic              bit_done_s;

  assign rx_s        = sync2_r;
  // A start needs a high-to-low transition, so after a frame error (line
  // stuck low) the receiver stays idle until the line has been high again.
  assign fall_s      = rx_prev_r & ~rx_s;
  assign half_done_s = (cnt_r == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_done_s  = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser plus previous-sample register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // Receive FSM with baud counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      shift_r      <= '0;
      par_bit_r    <= 1'b0;
      read_vld_r   <= 1'b0;
      read_data_r  <= '0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      read_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          idx_r <= '0;
          if (fall_s) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (half_done_s) begin
            cnt_r <= '0;
            // Start bit gone high by mid-bit: treat as a glitch.
            if (rx_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[DATA_W-1:1]};
            if (idx_r == IDX_W'(DATA_W - 1)) begin
              idx_r <= '0;
              if (PARITY != 0) begin
                state_r <= ST_PAR;
              end else begin
                state_r <= ST_STOP;
              end
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_PAR: begin
          if (bit_done_s) begin
            cnt_r     <= '0;
            par_bit_r <= rx_s;
            state_r   <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Only the first stop bit is checked; later stop bits are idle-high.
          if (bit_done_s) begin
            cnt_r       <= '0;
            read_vld_r  <= 1'b1;
            read_data_r <= shift_r;
            frame_err_r <= ~rx_s;
            if (PARITY != 0) begin
              parity_err_r <= (par_bit_r != calc_parity(16'(shift_r), 2'(PARITY)));
            end else begin
              parity_err_r <= 1'b0;
            end
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign read_vld   = read_vld_r;
  assign read_data  = read_data_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/uart_param_txrx.sv
// -----------------------------------------------------------------------------
// uart_param_txrx
// Parameterised full-duplex UART. Transmitter and its baud counter live here;
// the receiver is uart_rx_fsm. TX and RX run independently.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   cmd_in      word to transmit, latched on cmd_vld && cmd_rdy
//   cmd_vld     cmd_in valid
//   cmd_rdy     transmitter idle
//   tx          serial output, idle high
//   rx          asynchronous serial input
//   read_vld    one-cycle pulse, received word valid
//   read_data   last received word
//   parity_err  parity mismatch (qualified by read_vld)
//   frame_err   stop bit sampled low (qualified by read_vld)
// -----------------------------------------------------------------------------
module uart_param_txrx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_in,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  output logic              tx,
  input  logic              rx,
  output logic              read_vld,
  output logic [DATA_W-1:0] read_data,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  uart_state_e       tx_state_r;
  logic [CNT_W-1:0]  tx_cnt_r;
  logic [IDX_W-1:0]  tx_idx_r;
  logic              tx_stop_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic              tx_par_r;
  logic              tx_r;
  logic              cmd_rdy_r;
  logic              bit_done_s;

  assign bit_done_s = (tx_cnt_r == CNT_W'(CLKS_PER_BIT - 1));

  // Transmit FSM: each state drives one bit for CLKS_PER_BIT cycles; the
  // next bit value is registered onto tx at the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_idx_r   <= '0;
      tx_stop_r  <= 1'b0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      tx_r       <= 1'b1;
      cmd_rdy_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          tx_cnt_r  <= '0;
          tx_idx_r  <= '0;
          tx_stop_r <= 1'b0;
          if (cmd_vld && cmd_rdy_r) begin
            tx_shift_r <= cmd_in;
            tx_par_r   <= calc_parity(16'(cmd_in), 2'(PARITY));
            tx_r       <= 1'b0;
            cmd_rdy_r  <= 1'b0;
            tx_state_r <= ST_START;
          end else begin
            tx_r      <= 1'b1;
            cmd_rdy_r <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            tx_cnt_r   <= '0;
            tx_r       <= tx_shift_r[0];
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            tx_cnt_r <= '0;
            if (tx_idx_r == IDX_W'(DATA_W - 1)) begin
              if (PARITY != 0) begin
                tx_r       <= tx_par_r;
                tx_state_r <= ST_PAR;
              end else begin
                tx_r       <= 1'b1;
                tx_state_r <= ST_STOP;
              end
            end else begin
              tx_idx_r   <= tx_idx_r + IDX_W'(1);
              tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
              tx_r       <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        ST_PAR: begin
          if (bit_done_s) begin
            tx_cnt_r   <= '0;
            tx_r       <= 1'b1;
            tx_state_r <= ST_STOP;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            tx_cnt_r <= '0;
            if (tx_stop_r == 1'(STOP_BITS - 1)) begin
              cmd_rdy_r  <= 1'b1;
              tx_state_r <= ST_IDLE;
            end else begin
              tx_stop_r <= 1'b1;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          tx_cnt_r   <= '0;
          tx_r       <= 1'b1;
          cmd_rdy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_r;
  assign cmd_rdy = cmd_rdy_r;

  uart_rx_fsm #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .read_vld   (read_vld),
    .read_data  (read_data),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

endmodule
